// File: rtl/jtframe_vu_osd_if.sv
// jtframe_vu_osd_if: video/meter bus between the game video path and the VU overlay
// Ports: pxl_cen, LHBL, LVBL, vu, peak, enable, rgb_in drive the overlay; rgb_out returns the mixed pixel
interface jtframe_vu_osd_if;
  logic        pxl_cen;
  logic        LHBL;
  logic        LVBL;
  logic [7:0]  vu;
  logic        peak;
  logic        enable;
  logic [23:0] rgb_in;
  logic [23:0] rgb_out;
  modport master (output pxl_cen, LHBL, LVBL, vu, peak, enable, rgb_in, input rgb_out);
  modport slave  (input pxl_cen, LHBL, LVBL, vu, peak, enable, rgb_in, output rgb_out);
endinterface

// File: rtl/jtframe_vu_osd.sv
// jtframe_vu_osd: frame-rate VU meter ballistics and 8-segment bar overlay on game video
// Ports: clk system clock, rst_n async active-low reset, bus.slave carries the video/meter signals
module jtframe_vu_osd #(
  parameter int HPOS     = 16,
  parameter int VPOS     = 16,
  parameter int SEGW_LOG = 2,
  parameter int BARH     = 4,
  parameter int HOLD     = 30,
  parameter int DECAY    = 4,
  parameter int CLIPF    = 60
) (
  input logic clk,
  input logic rst_n,
  jtframe_vu_osd_if.slave bus
);
  localparam int DW = $clog2(DECAY + 1);
  localparam int HW = $clog2(HOLD + 1);
  localparam int CW = $clog2(CLIPF + 1);
  localparam logic [DW-1:0] DLAST = DW'(DECAY - 1);
  localparam logic [HW-1:0] HLAST = HW'(HOLD - 1);
  localparam logic [CW-1:0] CFULL = CW'(CLIPF);
  localparam logic [15:0] GMASK = 16'((1 << SEGW_LOG) - 1);
  logic [3:0] in_lvl, fmax, lvl, hlvl;
  logic [DW-1:0] dcnt;
  logic [HW-1:0] hcnt;
  logic [CW-1:0] ccnt;
  logic clip_seen, lvbl_l, lhbl_l, tick;
  logic [15:0] x, y, dx, s;
  logic in_rows, in_bar, in_lamp, gap;
  logic [23:0] col;
  // highest set bit wins, so non-thermometer codes still decode sensibly
  always_comb begin
    in_lvl = 4'd0;
    for (int i = 0; i < 8; i++) if (bus.vu[i]) in_lvl = 4'(i + 1);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lvbl_l    <= 1'b1;
      tick      <= 1'b0;
      fmax      <= 4'd0;
      clip_seen <= 1'b0;
      lvl       <= 4'd0;
      hlvl      <= 4'd0;
      dcnt      <= '0;
      hcnt      <= '0;
      ccnt      <= '0;
    end else begin
      lvbl_l    <= bus.LVBL;
      tick      <= lvbl_l & ~bus.LVBL;
      // the tick cycle's sample opens the new frame instead of being dropped
      fmax      <= tick ? in_lvl : (in_lvl > fmax ? in_lvl : fmax);
      clip_seen <= tick ? bus.peak : clip_seen | bus.peak;
      if (tick) begin
        if (fmax > lvl) begin
          lvl  <= fmax;
          dcnt <= '0;
        end else if (dcnt == DLAST) begin
          lvl  <= lvl - {3'd0, lvl != 4'd0};
          dcnt <= '0;
        end else dcnt <= dcnt + 1'b1;
        // hcnt parks at HOLD-1 so the marker then falls one segment per frame
        if (fmax >= hlvl) begin
          hlvl <= fmax;
          hcnt <= '0;
        end else if (hcnt == HLAST) hlvl <= hlvl - {3'd0, hlvl != 4'd0};
        else hcnt <= hcnt + 1'b1;
        ccnt <= clip_seen ? CFULL : ccnt - CW'(ccnt != '0);
      end
    end
  end
  always_comb begin
    dx      = x - 16'(HPOS);
    s       = dx >> SEGW_LOG;
    in_rows = y >= 16'(VPOS) && y < 16'(VPOS + BARH);
    in_bar  = in_rows && x >= 16'(HPOS) && s < 16'd8;
    in_lamp = in_rows && x >= 16'(HPOS) && s == 16'd9;
    gap     = (dx & GMASK) == GMASK;
    col     = in_lamp ? (ccnt != '0 ? 24'hFF0000 : bus.rgb_in) :
              s < {12'd0, lvl} ? (s < 16'd5 ? 24'h00E000 : s < 16'd7 ? 24'hE0E000 : 24'hE00000) :
              (s == {12'd0, hlvl} - 16'd1 && hlvl > lvl) ? 24'hFFFFFF : 24'h202020;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x           <= 16'd0;
      y           <= 16'd0;
      lhbl_l      <= 1'b1;
      bus.rgb_out <= 24'd0;
    end else if (bus.pxl_cen) begin
      lhbl_l      <= bus.LHBL;
      x           <= bus.LHBL ? x + 16'd1 : 16'd0;
      y           <= !bus.LVBL ? 16'd0 : (bus.LHBL & ~lhbl_l) ? y + 16'd1 : y;
      bus.rgb_out <= (bus.enable & bus.LHBL & bus.LVBL & (in_bar | in_lamp) & ~gap) ? col : bus.rgb_in;
    end
  end
endmodule
